cache_set_assoc: RTL

- Parametrised successor to the single-entry cache set: one N-way set-associative cache set with tag compare, per-way valid bits, true-LRU replacement and a flush walker.
- Requests enter through a valid/ready handshake. Each response, including any eviction information, is held in a one-entry output register until the consumer accepts it.
- Sits between the cache controller (request side) and the fill/writeback path (response side).

---
 rtl/cache_set_assoc.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_set_assoc.sv
// ---------------------------------------------------------------------------
// cache_set_assoc
//   One N-way set-associative cache set: tag compare, per-way valid bits,
//   true-LRU replacement and a flush walker. Requests arrive over a
//   valid/ready handshake. Every response, including eviction information,
//   sits in a one-entry output register until the consumer takes it.
//
// Ports
//   clock            rising-edge clock
//   clear_n          asynchronous active-low reset
//   req_valid/ready  request handshake
//   req_op           0 READ, 1 WRITE, 2 INVAL, 3 FLUSH
//   req_tag          lookup tag (ignored for FLUSH)
//   req_data         write data (WRITE only)
//   rsp_valid/ready  response handshake
//   rsp_hit          tag matched a valid way
//   rsp_way          way hit, allocated or flushed
//   rsp_data         read / invalidated data, 0 on miss
//   rsp_evict        rsp_evict_tag/data carry a displaced valid line
//   rsp_evict_tag    tag of the displaced line
//   rsp_evict_data   data of the displaced line
//   rsp_last         final response of an operation
// ---------------------------------------------------------------------------
module cache_set_assoc #(
  parameter int WAYS   = 4,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic [DATA_W-1:0]       req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_hit,
  output logic [$clog2(WAYS)-1:0] rsp_way,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_evict,
  output logic [TAG_W-1:0]        rsp_evict_tag,
  output logic [DATA_W-1:0]       rsp_evict_data,
  output logic                    rsp_last
);

  localparam int WAY_W = $clog2(WAYS);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, FLUSH_WALK, FLUSH_DONE} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INVAL, OP_FLUSH} op_e;

  // Architectural state
  state_e                  state_q, state_d;
  logic [WAY_W-1:0]        idx_q, idx_d;
  logic [WAYS-1:0]         valid_q, valid_d;
  logic [WAY_W-1:0]        age_q [WAYS];
  logic [WAY_W-1:0]        age_d [WAYS];
  logic [TAG_W-1:0]        tag_q [WAYS];
  logic [DATA_W-1:0]       data_q [WAYS];

  // Response register
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic [WAY_W-1:0]        rsp_way_q, rsp_way_d;
  logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
  logic                    rsp_evict_q, rsp_evict_d;
  logic [TAG_W-1:0]        rsp_evict_tag_q, rsp_evict_tag_d;
  logic [DATA_W-1:0]       rsp_evict_data_q, rsp_evict_data_d;
  logic                    rsp_last_q, rsp_last_d;

  // Control
  logic                    rsp_free;
  logic                    accept;
  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic                    inv_found;
  logic [WAY_W-1:0]        victim_way;
  logic                    touch_en;
  logic [WAY_W-1:0]        touch_way;
  logic                    arr_we;
  logic [WAY_W-1:0]        arr_way;

  // The register can take a new response if it is empty or being drained
  // this very cycle; a load in the same cycle as a drain simply replaces it.
  assign rsp_free  = !rsp_valid_q || rsp_ready;
  assign req_ready = (state_q == IDLE) && rsp_free;
  assign accept    = req_valid && req_ready;

  // Tag lookup. Duplicate tags are never created, so at most one way matches.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    inv_found  = 1'b0;
    victim_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!valid_q[i] && !inv_found) begin
        inv_found  = 1'b1;
        victim_way = WAY_W'(i);
      end
    end
    if (!inv_found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_q[i] == LAST_WAY) victim_way = WAY_W'(i);
      end
    end
  end

  // True-LRU touch: ways younger than the touched way age by one, the
  // touched way becomes age 0. This keeps ages a permutation of 0..WAYS-1.
  always_comb begin
    for (int i = 0; i < WAYS; i++) age_d[i] = age_q[i];
    if (touch_en) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_q[i] < age_q[touch_way]) age_d[i] = age_q[i] + 1'b1;
      end
      age_d[touch_way] = '0;
    end
  end

  // Next-state, array write and response generation.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    valid_d          = valid_q;
    touch_en         = 1'b0;
    touch_way        = hit_way;
    arr_we           = 1'b0;
    arr_way          = victim_way;
    rsp_valid_d      = rsp_valid_q && !rsp_ready;
    rsp_hit_d        = rsp_hit_q;
    rsp_way_d        = rsp_way_q;
    rsp_data_d       = rsp_data_q;
    rsp_evict_d      = rsp_evict_q;
    rsp_evict_tag_d  = rsp_evict_tag_q;
    rsp_evict_data_d = rsp_evict_data_q;
    rsp_last_d       = rsp_last_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_e'(req_op) == OP_FLUSH) begin
            state_d = FLUSH_WALK;
            idx_d   = '0;
          end else begin
            // READ / WRITE / INVAL all produce a single final response.
            rsp_valid_d      = 1'b1;
            rsp_hit_d        = hit;
            rsp_way_d        = hit ? hit_way : '0;
            rsp_data_d       = '0;
            rsp_evict_d      = 1'b0;
            rsp_evict_tag_d  = '0;
            rsp_evict_data_d = '0;
            rsp_last_d       = 1'b1;
            unique case (op_e'(req_op))
              OP_READ: begin
                if (hit) begin
                  rsp_data_d = data_q[hit_way];
                  touch_en   = 1'b1;
                end
              end
              OP_WRITE: begin
                arr_we   = 1'b1;
                touch_en = 1'b1;
                if (hit) begin
                  arr_way = hit_way;
                end else begin
                  arr_way             = victim_way;
                  touch_way           = victim_way;
                  valid_d[victim_way] = 1'b1;
                  rsp_way_d           = victim_way;
                  if (valid_q[victim_way]) begin
                    rsp_evict_d      = 1'b1;
                    rsp_evict_tag_d  = tag_q[victim_way];
                    rsp_evict_data_d = data_q[victim_way];
                  end
                end
              end
              OP_INVAL: begin
                if (hit) begin
                  valid_d[hit_way] = 1'b0;
                  rsp_data_d       = data_q[hit_way];
                end
              end
              default: ;
            endcase
          end
        end
      end

      FLUSH_WALK: begin
        // Stall only when the current way needs a response slot and none
        // is available; invalid ways are skipped without a response.
        if (!valid_q[idx_q] || rsp_free) begin
          if (valid_q[idx_q]) begin
            rsp_valid_d      = 1'b1;
            rsp_hit_d        = 1'b0;
            rsp_way_d        = idx_q;
            rsp_data_d       = '0;
            rsp_evict_d      = 1'b1;
            rsp_evict_tag_d  = tag_q[idx_q];
            rsp_evict_data_d = data_q[idx_q];
            rsp_last_d       = 1'b0;
            valid_d[idx_q]   = 1'b0;
          end
          if (idx_q == LAST_WAY) state_d = FLUSH_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end

      FLUSH_DONE: begin
        if (rsp_free) begin
          rsp_valid_d      = 1'b1;
          rsp_hit_d        = 1'b0;
          rsp_way_d        = '0;
          rsp_data_d       = '0;
          rsp_evict_d      = 1'b0;
          rsp_evict_tag_d  = '0;
          rsp_evict_data_d = '0;
          rsp_last_d       = 1'b1;
          state_d          = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      valid_q          <= '0;
      for (int i = 0; i < WAYS; i++) age_q[i] <= WAY_W'(i);
      rsp_valid_q      <= 1'b0;
      rsp_hit_q        <= 1'b0;
      rsp_way_q        <= '0;
      rsp_data_q       <= '0;
      rsp_evict_q      <= 1'b0;
      rsp_evict_tag_q  <= '0;
      rsp_evict_data_q <= '0;
      rsp_last_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      valid_q          <= valid_d;
      for (int i = 0; i < WAYS; i++) age_q[i] <= age_d[i];
      rsp_valid_q      <= rsp_valid_d;
      rsp_hit_q        <= rsp_hit_d;
      rsp_way_q        <= rsp_way_d;
      rsp_data_q       <= rsp_data_d;
      rsp_evict_q      <= rsp_evict_d;
      rsp_evict_tag_q  <= rsp_evict_tag_d;
      rsp_evict_data_q <= rsp_evict_data_d;
      rsp_last_q       <= rsp_last_d;
    end
  end

  // NOTE: the tag/data arrays have no reset; the valid bits alone decide
  // whether their contents mean anything, so they can map to plain storage.
  always_ff @(posedge clock) begin
    if (arr_we) begin
      tag_q[arr_way]  <= req_tag;
      data_q[arr_way] <= req_data;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_hit        = rsp_hit_q;
  assign rsp_way        = rsp_way_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_evict      = rsp_evict_q;
  assign rsp_evict_tag  = rsp_evict_tag_q;
  assign rsp_evict_data = rsp_evict_data_q;
  assign rsp_last       = rsp_last_q;

endmodule
